// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the 64-bit byte-addressed, little-endian data memory port.
// Serves one load or store at a time: range check, sub-word load extension and read-modify-write stores.
module mem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_adr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_adr,
  output logic [63:0] mem_datain,
  output logic        mem_w,
  output logic        mem_r,
  input  logic [63:0] mem_dataout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [63:0] adr_q;
  logic [63:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;

  logic [3:0]  req_nbytes;
  logic [64:0] req_end;
  logic        req_err;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_nbytes = 4'd1;
    case (req_size)
      2'b01:   req_nbytes = 4'd2;
      2'b10:   req_nbytes = 4'd4;
      2'b11:   req_nbytes = 4'd8;
      default: req_nbytes = 4'd1;
    endcase
  end

  // 65-bit sum so an address that wraps past 2^64 is still flagged as out of range.
  assign req_end = {1'b0, req_adr} + {61'b0, req_nbytes};
  assign req_err = req_end > 65'(MEM_BYTES);

  function automatic logic [63:0] extend(input logic [1:0] size, input logic uns,
                                         input logic [63:0] d);
    case (size)
      2'b00:   return uns ? {56'b0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      2'b01:   return uns ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      2'b10:   return uns ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  // Only the low bytes change; the rest of the memory word is written back as read.
  function automatic logic [63:0] merge(input logic [1:0] size, input logic [63:0] dout,
                                        input logic [63:0] wd);
    case (size)
      2'b00:   return {dout[63:8],  wd[7:0]};
      2'b01:   return {dout[63:16], wd[15:0]};
      2'b10:   return {dout[63:32], wd[31:0]};
      default: return wd;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      adr_q        <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            adr_q   <= req_adr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            if (req_err) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_we) begin
              state_q <= S_LOAD;
            end else if (req_size == 2'b11) begin
              state_q <= S_WRITE;
            end else begin
              state_q <= S_RMW_RD;
            end
          end
        end
        S_LOAD: begin
          resp_rdata_q <= extend(size_q, uns_q, mem_dataout);
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RMW_RD: begin
          wdata_q <= merge(size_q, mem_dataout, wdata_q);
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory strobes decode from state alone, so reset removes mem_w before the next edge.
  assign req_ready  = (state_q == S_IDLE);
  assign mem_adr    = adr_q;
  assign mem_r      = (state_q == S_LOAD) || (state_q == S_RMW_RD);
  assign mem_w      = (state_q == S_WRITE);
  assign mem_datain = (state_q == S_WRITE) ? wdata_q : 64'd0;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a 256-byte memory model on the port, a byte-level reference
// memory and a scoreboard queue of expected responses.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_adr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_adr;
  logic [63:0] mem_datain;
  logic        mem_w;
  logic        mem_r;
  logic [63:0] mem_dataout;

  mem_access_ctrl #(.MEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_adr(req_adr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_adr(mem_adr), .mem_datain(mem_datain),
    .mem_w(mem_w), .mem_r(mem_r), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  longint cyc = 0;
  always @(posedge clk) cyc++;

  // Attached data memory: combinational little-endian read, posedge write, bytes past 255 dropped.
  logic [7:0]  mem [0:255];
  logic [7:0]  ref_mem [0:255];
  logic [64:0] rd_a;
  logic [64:0] wr_a;

  always_comb begin
    mem_dataout = '0;
    rd_a = '0;
    for (int i = 0; i < 8; i++) begin
      rd_a = {1'b0, mem_adr} + 65'(i);
      if (rd_a < 65'd256) mem_dataout[8*i +: 8] = mem[rd_a[7:0]];
    end
  end

  always @(posedge clk) begin
    if (mem_w) begin
      for (int i = 0; i < 8; i++) begin
        wr_a = {1'b0, mem_adr} + 65'(i);
        if (wr_a < 65'd256) mem[wr_a[7:0]] <= mem_datain[8*i +: 8];
      end
    end
  end

  // Port monitor.
  int cnt_r = 0, cnt_w = 0, cnt_acc = 0, both_hi = 0, stray = 0, rdy_bad = 0;
  logic [63:0] last_wdata = '0;
  logic [63:0] last_wadr = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_r && mem_w) both_hi++;
      if (!mem_w && mem_datain !== 64'd0) stray++;
      if (req_ready && (mem_r || mem_w || resp_valid)) rdy_bad++;
      if (mem_r) cnt_r++;
      if (mem_w) begin
        cnt_w++;
        last_wdata = mem_datain;
        last_wadr  = mem_adr;
      end
      if (req_valid && req_ready) cnt_acc++;
    end
  end

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          nr;
    int          nw;
    longint      acc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] adr;
    logic [63:0] wd;
    logic [63:0] lit;
  } req_t;

  exp_t sb[$];

  // Drives one request, waits for acceptance and, when model is set, pushes the expected response.
  task automatic send(input req_t r, input bit keep, input bit model);
    exp_t        e;
    int          nb;
    int          guard;
    logic [64:0] endp;
    logic [63:0] v;
    req_we = r.we; req_size = r.size; req_unsigned = r.uns;
    req_adr = r.adr; req_wdata = r.wd; req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready=%b want=1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (!keep) req_valid = 1'b0;
    if (!model) return;
    nb   = 1 << r.size;
    endp = {1'b0, r.adr} + 65'(nb);
    e.err = endp > 65'd256;
    e.rdata = '0;
    if (e.err) begin
      e.lat = 1; e.nr = 0; e.nw = 0;
    end else if (r.we) begin
      for (int i = 0; i < nb; i++) ref_mem[8'(r.adr + 64'(i))] = r.wd[8*i +: 8];
      e.lat = (r.size == 2'b11) ? 2 : 3;
      e.nr  = (r.size == 2'b11) ? 0 : 1;
      e.nw  = 1;
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[8'(r.adr + 64'(i))];
      if (!r.uns && nb < 8 && v[8*nb-1])
        for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
      e.rdata = v; e.lat = 2; e.nr = 1; e.nw = 0;
    end
    sb.push_back(e);
  endtask

  // Waits (bounded) for a response pulse, pops its expectation and returns both.
  task automatic get_resp(output bit ok, output exp_t got, output exp_t e);
    int guard = 0;
    ok = 1'b0;
    while (resp_valid !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (resp_valid !== 1'b1) begin
      total++; bad++;
      $display("FAIL resp_timeout: resp_valid=%b want=1", resp_valid);
      return;
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_resp: queue_depth=0 want>0");
      @(posedge clk); #1;
      return;
    end
    e = sb.pop_front();
    got.err   = resp_err;
    got.rdata = resp_rdata;
    got.lat   = int'(cyc - e.acc) + 1;
    ok = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total += 3;
    if ({resp_valid, resp_err, mem_w, mem_r} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes: got=%b want=0000", {resp_valid, resp_err, mem_w, mem_r});
    end
    if (resp_rdata !== 64'd0) begin
      bad++; $display("FAIL reset_rdata: got=%h want=0", resp_rdata);
    end
    if ({mem_adr, mem_datain} !== 128'd0) begin
      bad++; $display("FAIL reset_mem_bus: adr=%h din=%h want=0", mem_adr, mem_datain);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got=%b want=1", req_ready);
    end
  endtask

  task automatic test_loads();
    req_t tbl[7];
    exp_t got, e;
    bit   ok;
    int   r0, w0;
    tbl[0] = '{1'b0, 2'b00, 1'b0, 64'h80, 64'd0, 64'hFFFFFFFFFFFFFF80};
    tbl[1] = '{1'b0, 2'b00, 1'b1, 64'h80, 64'd0, 64'h0000000000000080};
    tbl[2] = '{1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 64'h1716151413121110};
    tbl[3] = '{1'b0, 2'b01, 1'b0, 64'h7F, 64'd0, 64'hFFFFFFFFFFFF807F};
    tbl[4] = '{1'b0, 2'b10, 1'b1, 64'h7C, 64'd0, 64'h000000007F7E7D7C};
    tbl[5] = '{1'b0, 2'b10, 1'b0, 64'hFC, 64'd0, 64'hFFFFFFFFFFFEFDFC};
    tbl[6] = '{1'b0, 2'b11, 1'b0, 64'hF8, 64'd0, 64'hFFFEFDFCFBFAF9F8};
    foreach (tbl[k]) begin
      r0 = cnt_r; w0 = cnt_w;
      send(tbl[k], 1'b0, 1'b1);
      get_resp(ok, got, e);
      if (ok) begin
        total += 5;
        if (got.err !== e.err) begin
          bad++; $display("FAIL load%0d_err: got=%b want=%b", k, got.err, e.err);
        end
        if (got.rdata !== e.rdata) begin
          bad++; $display("FAIL load%0d_rdata: got=%h want=%h", k, got.rdata, e.rdata);
        end
        if (got.rdata !== tbl[k].lit) begin
          bad++; $display("FAIL load%0d_literal: got=%h want=%h", k, got.rdata, tbl[k].lit);
        end
        if (got.lat !== e.lat) begin
          bad++; $display("FAIL load%0d_latency: got=%0d want=%0d", k, got.lat, e.lat);
        end
        if (cnt_r - r0 !== e.nr || cnt_w - w0 !== e.nw) begin
          bad++; $display("FAIL load%0d_strobes: r=%0d w=%0d want r=%0d w=%0d",
                          k, cnt_r - r0, cnt_w - w0, e.nr, e.nw);
        end
      end
    end
  endtask

  task automatic test_stores();
    req_t tbl[8];
    exp_t got, e;
    bit   ok;
    int   r0, w0;
    tbl[0] = '{1'b1, 2'b01, 1'b0, 64'h20, 64'h1234ABCD, 64'd0};
    tbl[1] = '{1'b0, 2'b11, 1'b0, 64'h20, 64'd0, 64'h272625242322ABCD};
    tbl[2] = '{1'b1, 2'b00, 1'b0, 64'hFF, 64'h5A, 64'd0};
    tbl[3] = '{1'b0, 2'b00, 1'b1, 64'hFF, 64'd0, 64'h5A};
    tbl[4] = '{1'b1, 2'b10, 1'b1, 64'h33, 64'hDEADBEEFCAFEF00D, 64'd0};
    tbl[5] = '{1'b0, 2'b11, 1'b0, 64'h30, 64'd0, 64'h37CAFEF00D323130};
    tbl[6] = '{1'b1, 2'b11, 1'b0, 64'h50, 64'h0123456789ABCDEF, 64'd0};
    tbl[7] = '{1'b0, 2'b11, 1'b0, 64'h50, 64'd0, 64'h0123456789ABCDEF};
    foreach (tbl[k]) begin
      r0 = cnt_r; w0 = cnt_w;
      send(tbl[k], 1'b0, 1'b1);
      get_resp(ok, got, e);
      if (ok) begin
        total += 4;
        if (got.err !== e.err || got.rdata !== e.rdata) begin
          bad++; $display("FAIL store%0d_resp: err=%b rdata=%h want err=%b rdata=%h",
                          k, got.err, got.rdata, e.err, e.rdata);
        end
        if (got.rdata !== tbl[k].lit) begin
          bad++; $display("FAIL store%0d_literal: got=%h want=%h", k, got.rdata, tbl[k].lit);
        end
        if (got.lat !== e.lat) begin
          bad++; $display("FAIL store%0d_latency: got=%0d want=%0d", k, got.lat, e.lat);
        end
        if (cnt_r - r0 !== e.nr || cnt_w - w0 !== e.nw) begin
          bad++; $display("FAIL store%0d_strobes: r=%0d w=%0d want r=%0d w=%0d",
                          k, cnt_r - r0, cnt_w - w0, e.nr, e.nw);
        end
        if (k == 0) begin
          total += 2;
          if (last_wdata !== 64'h272625242322ABCD) begin
            bad++; $display("FAIL half_merge_word: got=%h want=272625242322abcd", last_wdata);
          end
          if (last_wadr !== 64'h20) begin
            bad++; $display("FAIL half_write_adr: got=%h want=20", last_wadr);
          end
        end
      end
    end
  endtask

  task automatic test_range();
    req_t tbl[4];
    exp_t got, e;
    bit   ok;
    int   r0, w0;
    tbl[0] = '{1'b0, 2'b11, 1'b0, 64'hF9, 64'd0, 64'd0};
    tbl[1] = '{1'b0, 2'b01, 1'b1, 64'hFF, 64'd0, 64'd0};
    tbl[2] = '{1'b1, 2'b11, 1'b0, 64'hF9, 64'hFFFFFFFFFFFFFFFF, 64'd0};
    tbl[3] = '{1'b1, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h77, 64'd0};
    foreach (tbl[k]) begin
      r0 = cnt_r; w0 = cnt_w;
      send(tbl[k], 1'b0, 1'b1);
      get_resp(ok, got, e);
      if (ok) begin
        total += 4;
        if (got.err !== 1'b1 || e.err !== 1'b1) begin
          bad++; $display("FAIL range%0d_err: got=%b want=1", k, got.err);
        end
        if (got.rdata !== 64'd0) begin
          bad++; $display("FAIL range%0d_rdata: got=%h want=0", k, got.rdata);
        end
        if (got.lat !== e.lat) begin
          bad++; $display("FAIL range%0d_latency: got=%0d want=%0d", k, got.lat, e.lat);
        end
        if (cnt_r != r0 || cnt_w != w0) begin
          bad++; $display("FAIL range%0d_strobes: r=%0d w=%0d want 0 0", k, cnt_r - r0, cnt_w - w0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    req_t tbl[3];
    int   a0;
    a0 = cnt_acc;
    tbl[0] = '{1'b0, 2'b11, 1'b0, 64'h08, 64'd0, 64'd0};
    tbl[1] = '{1'b0, 2'b01, 1'b0, 64'h9E, 64'd0, 64'd0};
    tbl[2] = '{1'b0, 2'b00, 1'b1, 64'hC3, 64'd0, 64'd0};
    fork
      begin
        for (int k = 0; k < 3; k++) send(tbl[k], (k < 2), 1'b1);
      end
      begin
        exp_t got, e;
        bit   ok;
        for (int k = 0; k < 3; k++) begin
          get_resp(ok, got, e);
          if (ok) begin
            total += 2;
            if (got.err !== e.err || got.rdata !== e.rdata) begin
              bad++; $display("FAIL b2b%0d_resp: err=%b rdata=%h want err=%b rdata=%h",
                              k, got.err, got.rdata, e.err, e.rdata);
            end
            if (got.lat !== e.lat) begin
              bad++; $display("FAIL b2b%0d_latency: got=%0d want=%0d", k, got.lat, e.lat);
            end
          end
        end
      end
    join
    total += 2;
    if (cnt_acc - a0 !== 3) begin
      bad++; $display("FAIL b2b_accepts: got=%0d want=3", cnt_acc - a0);
    end
    if (sb.size() !== 0) begin
      bad++; $display("FAIL b2b_leftover: got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_reset_during_write();
    req_t st, ld;
    exp_t got, e;
    bit   ok;
    int   guard = 0;
    st = '{1'b1, 2'b00, 1'b0, 64'h40, 64'hEE, 64'd0};
    ld = '{1'b0, 2'b11, 1'b0, 64'h40, 64'd0, 64'h4746454443424140};
    send(st, 1'b0, 1'b0);
    while (mem_w !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (mem_w !== 1'b1) begin
      bad++; $display("FAIL rst_write_reached: mem_w=%b want=1", mem_w);
    end
    rst_n = 1'b0;
    #1;
    total += 2;
    if ({mem_w, mem_r, resp_valid} !== 3'b000) begin
      bad++; $display("FAIL rst_abort_strobes: got=%b want=000", {mem_w, mem_r, resp_valid});
    end
    if (mem_datain !== 64'd0) begin
      bad++; $display("FAIL rst_abort_datain: got=%h want=0", mem_datain);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_release_ready: got=%b want=1", req_ready);
    end
    send(ld, 1'b0, 1'b1);
    get_resp(ok, got, e);
    if (ok) begin
      total += 2;
      if (got.rdata !== e.rdata || got.rdata !== ld.lit) begin
        bad++; $display("FAIL rst_mem_intact: got=%h want=%h", got.rdata, ld.lit);
      end
      if (got.lat !== e.lat || got.err !== 1'b0) begin
        bad++; $display("FAIL rst_reload: lat=%0d err=%b want lat=%0d err=0", got.lat, got.err, e.lat);
      end
    end
  endtask

  task automatic test_invariants();
    total += 3;
    if (both_hi !== 0) begin
      bad++; $display("FAIL r_and_w: got=%0d want=0", both_hi);
    end
    if (stray !== 0) begin
      bad++; $display("FAIL datain_idle: got=%0d want=0", stray);
    end
    if (rdy_bad !== 0) begin
      bad++; $display("FAIL ready_outside_idle: got=%0d want=0", rdy_bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i);
      ref_mem[i] = 8'(i);
    end
    test_reset();
    test_loads();
    test_stores();
    test_range();
    test_back_to_back();
    test_reset_during_write();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
